// File: rtl/rf_1p_fifo_ctrl_pkg.sv
// rtl/rf_1p_fifo_ctrl_pkg.sv - RF op encoding and depth derivation for the single-port RF FIFO controller
package rf_1p_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_WR   = 2'd1,
    OP_RD   = 2'd2
  } rf_op_e;

  function automatic int rf_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/rf_1p_fifo_ctrl_if.sv
// rtl/rf_1p_fifo_ctrl_if.sv - push/pop valid-ready streams of the RF FIFO controller
interface rf_1p_fifo_ctrl_if #(
  parameter int Word_Width = 32
);
  logic                  push_valid_i;
  logic                  push_ready_o;
  logic [Word_Width-1:0] push_data_i;
  logic                  pop_valid_o;
  logic                  pop_ready_i;
  logic [Word_Width-1:0] pop_data_o;

  modport master (
    output push_valid_i, push_data_i, pop_ready_i,
    input  push_ready_o, pop_valid_o, pop_data_o
  );

  modport slave (
    input  push_valid_i, push_data_i, pop_ready_i,
    output push_ready_o, pop_valid_o, pop_data_o
  );
endinterface

// File: rtl/rf_1p_fifo_ctrl_fifo_out_buf2.sv
// rtl/rf_1p_fifo_ctrl_fifo_out_buf2.sv - 2-entry registered output buffer absorbing the RF read latency
module fifo_out_buf2 #(
  parameter int Word_Width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [Word_Width-1:0] push_data_i,
  input  logic                  pop_ready_i,
  output logic                  pop_valid_o,
  output logic [Word_Width-1:0] pop_data_o,
  output logic [1:0]            count_o
);
  logic [Word_Width-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  pop;

  assign pop = pop_ready_i && (cnt_q != 2'd0);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push_i, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = push_data_i;
        else               tail_d = push_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // simultaneous pop and push: the new word lands behind whatever remains
        if (cnt_q == 2'd1) begin
          head_d = push_data_i;
        end else begin
          head_d = tail_q;
          tail_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pop_valid_o = (cnt_q != 2'd0);
  assign pop_data_o  = head_q;
  assign count_o     = cnt_q;
endmodule

// File: rtl/rf_1p_fifo_ctrl.sv
// rtl/rf_1p_fifo_ctrl.sv - streaming FIFO controller driving a single-port RF, one RF op per cycle
// FIFO_BYPASS_EN: pushes into an otherwise empty FIFO skip the RF and land in the output buffer.
module rf_1p_fifo_ctrl
  import rf_1p_fifo_ctrl_pkg::*;
#(
  parameter int Word_Width = 32,
  parameter int Addr_Width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  rf_1p_fifo_ctrl_if.slave      bus,
  output logic [Addr_Width+1:0] count_o,
  output logic                  rf_cen_o,
  output logic                  rf_wen_o,
  output logic [Addr_Width-1:0] rf_addr_o,
  output logic [Word_Width-1:0] rf_data_o,
  input  logic [Word_Width-1:0] rf_data_i
);
  localparam int DEPTH = rf_depth(Addr_Width);
  localparam logic [Addr_Width:0] MemFull = (Addr_Width+1)'(DEPTH);

  logic [Addr_Width-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Addr_Width:0]   mem_cnt_q, mem_cnt_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic                  last_rd_q, last_rd_d;
  logic [1:0]            out_cnt;
  logic                  mem_full, mem_empty;
  logic                  rd_want, wr_want, rd_grant, wr_grant, bypass;
  logic                  buf_push, pop_valid;
  logic [Word_Width-1:0] buf_data, pop_data;
  rf_op_e                op;

  assign mem_full  = (mem_cnt_q == MemFull);
  assign mem_empty = (mem_cnt_q == '0);

  // a read is only issued when the buffer is guaranteed room for its data
  assign rd_want = !rst && !mem_empty && ((out_cnt + {1'b0, rd_inflight_q}) < 2'd2);

`ifdef FIFO_BYPASS_EN
  assign bypass = !rst && bus.push_valid_i && mem_empty && !rd_inflight_q && (out_cnt < 2'd2);
`else
  assign bypass = 1'b0;
`endif

  assign wr_want  = !rst && bus.push_valid_i && !mem_full && !bypass;
  assign rd_grant = rd_want && (!wr_want || !last_rd_q);
  assign wr_grant = wr_want && !rd_grant;

  // ready assumes a write is wanted, so it never depends on push_valid_i
  assign bus.push_ready_o = !rst && !mem_full && !(rd_want && !last_rd_q);

  always_comb begin
    op = OP_IDLE;
    if (rd_grant)      op = OP_RD;
    else if (wr_grant) op = OP_WR;
  end

  assign rf_cen_o  = (op == OP_IDLE);
  assign rf_wen_o  = (op != OP_WR);
  assign rf_addr_o = (op == OP_RD) ? rd_ptr_q : wr_ptr_q;
  assign rf_data_o = bus.push_data_i;

  always_comb begin
    wr_ptr_d      = wr_ptr_q + Addr_Width'(wr_grant);
    rd_ptr_d      = rd_ptr_q + Addr_Width'(rd_grant);
    mem_cnt_d     = mem_cnt_q + (Addr_Width+1)'(wr_grant) - (Addr_Width+1)'(rd_grant);
    rd_inflight_d = rd_grant;
    last_rd_d     = last_rd_q;
    if (rd_grant)      last_rd_d = 1'b1;
    else if (wr_grant) last_rd_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      last_rd_q     <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_cnt_q     <= mem_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      last_rd_q     <= last_rd_d;
    end
  end

  // rf_data_i is only selected while a read is in flight
  assign buf_push = rd_inflight_q || bypass;
  assign buf_data = rd_inflight_q ? rf_data_i : bus.push_data_i;

  fifo_out_buf2 #(.Word_Width(Word_Width)) u_out_buf (
    .clk        (clk),
    .rst        (rst),
    .push_i     (buf_push),
    .push_data_i(buf_data),
    .pop_ready_i(bus.pop_ready_i),
    .pop_valid_o(pop_valid),
    .pop_data_o (pop_data),
    .count_o    (out_cnt)
  );

  assign bus.pop_valid_o = pop_valid;
  assign bus.pop_data_o  = pop_data;

  assign count_o = (Addr_Width+2)'(mem_cnt_q) + (Addr_Width+2)'(out_cnt)
                 + (Addr_Width+2)'(rd_inflight_q);
endmodule

// File: tb/tb_rf_1p_fifo_ctrl.sv
// tb/tb_rf_1p_fifo_ctrl.sv - bench pairing rf_1p_fifo_ctrl with a behavioural rf_1p and a queue scoreboard
module tb_rf_1p_fifo_ctrl;
  localparam int WW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int CAP   = DEPTH + 2;
`ifdef FIFO_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_1p_fifo_ctrl_if #(.Word_Width(WW)) bus ();

  logic [AW+1:0] count;
  logic          rf_cen, rf_wen;
  logic [AW-1:0] rf_addr;
  logic [WW-1:0] rf_wdata, rf_rdata;

  rf_1p_fifo_ctrl #(.Word_Width(WW), .Addr_Width(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .count_o  (count),
    .rf_cen_o (rf_cen),
    .rf_wen_o (rf_wen),
    .rf_addr_o(rf_addr),
    .rf_data_o(rf_wdata),
    .rf_data_i(rf_rdata)
  );

  // behavioural single-port RF; garbage on the read port except the cycle after a read
  logic [WW-1:0] mem [DEPTH];
  logic [WW-1:0] rd_q;
  logic          rd_vld = 1'b0;
  int            rf_words = 0;
  always @(posedge clk) begin
    rd_vld <= 1'b0;
    if (!rf_cen) begin
      if (!rf_wen) mem[rf_addr] <= rf_wdata;
      else begin
        rd_q   <= mem[rf_addr];
        rd_vld <= 1'b1;
      end
    end
    if (rst)          rf_words <= 0;
    else if (!rf_cen) rf_words <= rf_wen ? rf_words - 1 : rf_words + 1;
  end
  assign rf_rdata = rd_vld ? rd_q : 32'hBADD_0000;

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [WW-1:0] q [$];
  int            n_push, n_pop, v, p0, lat;
  logic          last_push, got_pop, saw_rd;
  logic [WW-1:0] got_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive at negedge, sample just after, update model at posedge
  task automatic cycle(input logic pv, input logic [WW-1:0] pd, input logic pr);
    bus.push_valid_i = pv;
    bus.push_data_i  = pd;
    bus.pop_ready_i  = pr;
    #1;
    got_pop   = pr && bus.pop_valid_o;
    got_data  = bus.pop_data_o;
    last_push = pv && bus.push_ready_o;
    saw_rd    = !rf_cen && rf_wen;
    if (saw_rd) begin
      check("rd_from_empty_rf", rf_words != 0, 1);
      check("rd_without_buf_room", (q.size() - rf_words) < 2, 1);
    end
    if (!rf_cen && !rf_wen) check("wr_into_full_rf", rf_words < DEPTH, 1);
    if (pv && q.size() == CAP) check("ready_at_full", bus.push_ready_o, 0);
    if (got_pop) begin
      if (q.size() == 0) check("pop_valid_when_empty", bus.pop_valid_o, 0);
      else begin
        check("pop_data", got_data, q[0]);
        void'(q.pop_front());
      end
      n_pop++;
    end
    if (last_push) begin
      q.push_back(pd);
      n_push++;
    end
    @(posedge clk);
    @(negedge clk);
    check("count", count, q.size());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.push_valid_i = 1'b0;
    bus.pop_ready_i  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 200 && q.size() > 0; c++) cycle(1'b0, '0, 1'b1);
    check(tag, q.size(), 0);
  endtask

  initial begin
    bus.push_valid_i = 1'b0;
    bus.push_data_i  = '0;
    bus.pop_ready_i  = 1'b0;
    n_push = 0;
    n_pop  = 0;
    @(negedge clk);
    do_reset();
    #1;
    check("rst_count", count, 0);
    check("rst_pop_valid", bus.pop_valid_o, 0);
    check("rst_cen", rf_cen, 1);
    check("rst_wen", rf_wen, 1);
    check("rst_push_ready", bus.push_ready_o, 1);

    // single word latency
    cycle(1'b1, 32'hA5, 1'b1);
    check("a5_accepted", last_push, 1);
    lat = 99;
    for (int k = 1; k <= 10 && lat == 99; k++) begin
      cycle(1'b0, '0, 1'b1);
      if (got_pop) lat = k;
    end
    check("a5_latency", lat, EXP_LAT);
    check("a5_count_zero", count, 0);

    // fill to capacity with no consumer, then drain in order across pointer wrap
    do_reset();
    v = 1;
    for (int c = 0; c < 100 && v <= 10; c++) begin
      cycle(1'b1, WW'(v), 1'b0);
      if (last_push) v++;
    end
    check("fill_accepted", v - 1, 10);
    check("fill_count", count, CAP);
    cycle(1'b1, 32'h99, 1'b0);
    check("full_no_accept", last_push, 0);
    p0 = n_pop;
    drain("fill_drained");
    check("fill_pops", n_pop - p0, 10);

    // continuous push and pop: both sides must make progress
    p0 = n_pop;
    v  = n_push;
    for (int c = 0; c < 200; c++) cycle(1'b1, $urandom, 1'b1);
    check("cont_push_progress", (n_push - v) >= 90, 1);
    check("cont_pop_progress", (n_pop - p0) >= 90, 1);
    drain("cont_drained");

    // random backpressure on both sides
    for (int c = 0; c < 400; c++)
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1);
    drain("rand_drained");

    // reset with a read in flight and five words held
    do_reset();
    v = 0;
    for (int c = 0; c < 50 && v < 6; c++) begin
      cycle(1'b1, $urandom, 1'b0);
      if (last_push) v++;
    end
    for (int c = 0; c < 6; c++) cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);
    saw_rd = 1'b0;
    for (int c = 0; c < 5 && !saw_rd; c++) cycle(1'b0, '0, 1'b0);
    check("pre_rst_rd_issued", saw_rd, 1);
    check("pre_rst_count", count, 5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    #1;
    check("post_rst_count", count, 0);
    check("post_rst_pop_valid", bus.pop_valid_o, 0);
    check("post_rst_cen", rf_cen, 1);
    for (int c = 0; c < 3; c++) cycle(1'b0, '0, 1'b1);
    for (int c = 0; c < 3; c++) cycle(1'b1, $urandom, 1'b0);
    drain("post_rst_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
